// File: rtl/machine_pkg.sv
// Shared state codes and default parameter values for the machine_seq sequencer.
package machine_pkg;

    localparam int ST_W      = 3;
    localparam int DEF_DLY_A = 2;
    localparam int DEF_DLY_B = 2;
    localparam int DEF_TO    = 16;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [ST_W-1:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        TEST   = 3'd2,
        PATH_A = 3'd3,
        PATH_B = 3'd4,
        JOIN   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/machine_cnt.sv
// Loadable up/down counter with zero flag; load has priority over enable.
module machine_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= up ? cnt + ONE : cnt - ONE;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/machine_seq.sv
// Moore branch sequencer: init, test, two timed paths, join, done, plus start/clear.
// Define MACHINE_SEQ_TIMEOUT_EN to add a TEST-state timeout that lands in ERR.
module machine_seq
    import machine_pkg::*;
#(
    parameter int DLY_A     = DEF_DLY_A,
    parameter int DLY_B     = DEF_DLY_B,
    parameter int TO_CYCLES = DEF_TO,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            clear,
    input  logic            x1,
    input  logic            x2,
    input  logic            x3,
    output logic            result,
    output logic            busy,
    output logic            error,
    output logic [ST_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] DLY_A_M1 = CNT_W'(DLY_A - 1);
    localparam logic [CNT_W-1:0] DLY_B_M1 = CNT_W'(DLY_B - 1);

    state_t state, nxt;

    logic             path_load, path_en, path_zero;
    logic [CNT_W-1:0] path_cnt_unused;
    logic             to_hit;

    // Path counter loads whenever TEST branches, so it holds DLY-1 on the first path cycle.
    assign path_load = (state == TEST) && x2;
    assign path_en   = ((state == PATH_A) || (state == PATH_B)) && !path_zero;

    machine_cnt #(.CNT_W(CNT_W)) u_path_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (path_load),
        .load_val (x1 ? DLY_B_M1 : DLY_A_M1),
        .en       (path_en),
        .up       (1'b0),
        .cnt      (path_cnt_unused),
        .zero     (path_zero)
    );

`ifdef MACHINE_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TO_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             to_zero_unused;

    // INIT always precedes TEST, so clearing there gives a fresh count on TEST entry.
    machine_cnt #(.CNT_W(CNT_W)) u_to_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state == INIT),
        .load_val ('0),
        .en       (state == TEST),
        .up       (1'b1),
        .cnt      (to_cnt),
        .zero     (to_zero_unused)
    );

    assign to_hit = (to_cnt == TO_M1);
    assign error  = (state == ERR);
`else
    logic [CNT_W-1:0] to_cycles_unused;

    assign to_cycles_unused = CNT_W'(TO_CYCLES);
    assign to_hit           = 1'b0;
    assign error            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = INIT;
            INIT:    nxt = TEST;
            TEST: begin
                if (x2)
                    nxt = x1 ? PATH_B : PATH_A;
                else if (x3)
                    nxt = DONE;
                else if (to_hit)
                    nxt = ERR;
            end
            PATH_A,
            PATH_B:  if (path_zero) nxt = JOIN;
            JOIN:    nxt = DONE;
            DONE,
            ERR:     if (clear) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign result  = (state == JOIN) || (state == DONE);
    assign busy    = (state == INIT) || (state == TEST) || (state == PATH_A) ||
                     (state == PATH_B) || (state == JOIN);
    assign state_o = state;

endmodule

// File: tb/tb_machine_seq.sv
// Scoreboard bench for machine_seq: stimulus queues expected outputs, a monitor pops and checks.
module tb_machine_seq;

    logic       clk = 1'b0;
    logic       reset, start, clear, x1, x2, x3;
    logic       result, busy, error;
    logic [2:0] state_o;

    typedef struct packed {
        logic [2:0] st;
        logic       res;
        logic       bsy;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   tag    = 0;
    event chk_now;

    machine_seq #(.DLY_A(2), .DLY_B(5), .TO_CYCLES(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .clear   (clear),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .result  (result),
        .busy    (busy),
        .error   (error),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // Output table by state code: result in JOIN/DONE, busy INIT..JOIN, error in ERR.
    function automatic exp_t mk(input int s);
        exp_t e;
        e.st  = 3'(s);
        e.res = (s == 5) || (s == 6);
        e.bsy = (s >= 1) && (s <= 5);
        e.err = (s == 7);
        return e;
    endfunction

    // Drive inputs mid-cycle; expectation applies after the following rising edge.
    task automatic step(input logic s, input logic c, input logic a1, input logic a2,
                        input logic a3, input int exp_st);
        @(negedge clk);
        start = s; clear = c; x1 = a1; x2 = a2; x3 = a3;
        exp_q.push_back(mk(exp_st));
        tag_q.push_back(tag);
        tag++;
    endtask

    initial begin : monitor
        exp_t e, got;
        int   t;
        forever begin
            @(posedge clk or chk_now);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                got = {state_o, result, busy, error};
                n_chk++;
                if (got === e)
                    n_pass++;
                else
                    $display("FAIL step%0d: got st=%0d res=%b busy=%b err=%b, want st=%0d res=%b busy=%b err=%b",
                             t, got.st, got.res, got.bsy, got.err, e.st, e.res, e.bsy, e.err);
            end
        end
    end

    initial begin : stim
        reset = 1'b0; start = 1'b0; clear = 1'b0; x1 = 1'b0; x2 = 1'b0; x3 = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk(0)); tag_q.push_back(tag); tag++;
        -> chk_now;
        @(negedge clk);
        reset = 1'b1;

        // PATH_A, DLY_A=2: 1,2,3,3,5,6 then sticky DONE
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 1, 0, 3);
        step(0, 0, 1, 1, 1, 3);
        step(0, 0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 6);
        step(0, 0, 0, 0, 0, 6);

        // async reset while in DONE clears everything before any edge
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(mk(0)); tag_q.push_back(tag); tag++;
        -> chk_now;
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // PATH_B, DLY_B=5: five cycles at 4, inputs ignored meanwhile
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 1, 1, 0, 4);
        step(0, 0, 0, 0, 1, 4);
        step(1, 1, 0, 1, 0, 4);
        step(0, 0, 1, 1, 1, 4);
        step(0, 0, 0, 0, 0, 4);
        step(0, 0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 6);
        step(0, 1, 0, 0, 0, 0);

        // direct finish skips JOIN; start ignored in DONE; start+clear -> IDLE then INIT
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 6);
        step(1, 0, 0, 0, 0, 6);
        step(1, 0, 0, 0, 0, 6);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 6);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

`ifdef MACHINE_SEQ_TIMEOUT_EN
        // TO_CYCLES=4: four cycles in TEST then ERR
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 7);
        step(1, 0, 0, 1, 1, 7);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        // exit condition on the fourth TEST cycle wins over the timeout
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 6);
        step(0, 1, 0, 0, 0, 0);
`else
        // no timeout: TEST waits indefinitely with error low
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 2);
        for (int i = 0; i < 100; i++)
            step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 6);
        step(0, 1, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: sim time %0t reached, want finish earlier", $time);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $finish;
    end

endmodule

// File: doc/machine_seq.md
Name: machine_seq

Overview:
- Parametrised successor to the team's fixed Moore branch machine.
- Same flowchart skeleton: init, test, two delay paths, join, done. Adds start/clear control, configurable path delays, a TEST-state timeout with error state, and status outputs.
- Sits under a host controller that issues start/clear and reads result/busy/error/state.

Parameters:
- DLY_A, 2, cycles spent in PATH_A (legal 1..2^CNT_W-1).
- DLY_B, 2, cycles spent in PATH_B (legal 1..2^CNT_W-1).
- TO_CYCLES, 16, max cycles in TEST before ERR (legal 1..2^CNT_W-1; only used with the macro).
- CNT_W, 8, width of internal counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE only.
- clear  in  1  level; returns DONE/ERR to IDLE.
- x1  in  1  branch select (0 -> PATH_A, 1 -> PATH_B).
- x2  in  1  branch enable.
- x3  in  1  direct-finish condition.
- result  out  1  high in JOIN and DONE.
- busy  out  1  high in INIT, TEST, PATH_A, PATH_B, JOIN.
- error  out  1  high in ERR.
- state_o  out  3  current state code.

Behaviour:
- All outputs are Moore-decoded from the registered state. No input-to-output combinational path.
- reset low (async): state=IDLE, counters=0, result=0, busy=0, error=0, state_o=0. Reset mid-operation aborts immediately with no residue.
- State codes: IDLE=0, INIT=1, TEST=2, PATH_A=3, PATH_B=4, JOIN=5, DONE=6, ERR=7.
- IDLE: start=1 -> INIT; else stay.
- INIT: unconditional -> TEST (1 cycle).
- TEST, evaluated in priority order:
  - x2=1 & x1=0 -> PATH_A.
  - x2=1 & x1=1 -> PATH_B.
  - x2=0 & x3=1 -> DONE.
  - Otherwise stay.
- PATH_A/PATH_B:
  - Down-counter loads DLY_x-1 on entry.
  - State holds while counter != 0 and decrements each cycle. Counter == 0 -> JOIN.
  - Dwell is exactly DLY_x cycles. Inputs are ignored.
- JOIN: unconditional -> DONE (1 cycle).
- DONE: sticky. clear=1 -> IDLE. start is ignored in DONE.
- ERR: sticky. clear=1 -> IDLE.
- clear outside DONE/ERR is ignored. clear and start together in DONE -> IDLE; start is acted on the next cycle if still high.
- Latency with DLY_A=2: start seen at edge 0 -> INIT@1, TEST@2. Branch taken at edge 2 -> PATH_A@3..4, JOIN@5 (result=1), DONE@6.
- Direct finish: TEST with x2=0, x3=1 -> DONE next edge, skipping JOIN.
- Unreachable encodings are not possible with 3-bit codes (all 8 used). A default branch still returns to IDLE.

Optional Feature:
- Macro: MACHINE_SEQ_TIMEOUT_EN.
- Defined:
  - Timeout counter clears on entry to TEST and increments each cycle spent in TEST.
  - If the counter equals TO_CYCLES-1 and no exit condition holds, next state is ERR. Exit conditions win on that same cycle.
  - Total TEST dwell before ERR is exactly TO_CYCLES cycles.
- Undefined:
  - No timeout counter. TEST waits indefinitely, as in the earlier machine.
  - ERR is unreachable and error is tied 0.

Decomposition:
- Package machine_pkg: state code constants (IDLE..ERR), state width (3), default DLY/TO constants.
- One sub-module, machine_cnt: CNT_W loadable up/down counter with load, enable, zero flag. Instantiated for the path delay and, under the macro, for the timeout.

Test Plan:
- Reset in DONE: drive reset=0 while in DONE -> state_o=0 and result=0 immediately (before next edge); busy=0.
- PATH_A, DLY_A=2: start=1, then x2=1, x1=0 in TEST -> state_o 1,2,3,3,5,6. result rises at JOIN. busy falls entering DONE.
- PATH_B, DLY_B=5: x2=1, x1=1 -> exactly 5 cycles at state_o=4, then 5, then 6. clear=1 -> 0.
- Direct finish: x2=0, x3=1 in TEST -> TEST to DONE in one edge with no JOIN. start=1 held in DONE has no effect.
- Timeout, macro defined, TO_CYCLES=4: hold x2=0, x3=0 -> TEST for 4 cycles, then ERR and error=1.
  - Repeat with x3=1 on the 4th cycle -> DONE, not ERR.
  - Macro undefined: TEST held for 100 cycles, error stays 0.
- Simultaneous start and clear in ERR -> IDLE. With start still high -> INIT next edge.
